tt_um_count_checker: RTL and testbench



---
 rtl/tt_um_count_checker.sv | 103 ++++++++++
 tb/tb_tt_um_count_checker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_count_checker.sv
// tt_um_count_checker: locks onto a +1 mod 256 count stream on ui_in and counts sequence errors once locked.
// Optional CHK_DELTA_EN adds a delta capture register and a 2-bit readout select on uio_in[3:2].
module tt_um_count_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);
  localparam logic [2:0] LOSS_N = 3'(LOSS_CNT);
  state_t r_state, w_state_nxt;
  logic [7:0] r_prev, r_err_cnt, r_uo;
  logic [7:0] w_prev_nxt, w_err_nxt, w_err_base, w_exp, w_exp_nxt, w_uo_nxt;
  logic [2:0] r_match_run, r_miss_run, w_match_nxt, w_miss_nxt;
  logic       r_locked, r_acq, r_sat, r_pulse;
  logic       w_valid, w_match, w_err, w_unused;
  assign w_valid = uio_in[0];
  assign w_exp   = r_prev + 8'd1;
  assign w_match = ui_in == w_exp;
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_run;
    w_miss_nxt  = r_miss_run;
    w_err       = 1'b0;
    if (w_valid) begin
      case (r_state)
        IDLE: w_state_nxt = ACQUIRE;
        ACQUIRE: begin
          w_match_nxt = w_match ? r_match_run + 3'd1 : 3'd0;
          if (w_match && w_match_nxt == LOCK_N) begin
            w_state_nxt = LOCKED;
            w_miss_nxt  = 3'd0;
          end
        end
        LOCKED: begin
          w_err      = !w_match;
          w_miss_nxt = w_match ? 3'd0 : r_miss_run + 3'd1;
          if (!w_match && w_miss_nxt == LOSS_N) begin
            w_state_nxt = ACQUIRE;
            w_match_nxt = 3'd0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  // clear is applied before a same-cycle error is counted
  assign w_prev_nxt = w_valid ? ui_in : r_prev;
  assign w_err_base = uio_in[1] ? 8'd0 : r_err_cnt;
  assign w_err_nxt  = (w_err && w_err_base != 8'hFF) ? w_err_base + 8'd1 : w_err_base;
  assign w_exp_nxt  = (w_state_nxt == IDLE) ? 8'd0 : w_prev_nxt + 8'd1;
`ifdef CHK_DELTA_EN
  logic [7:0] r_delta, w_delta_nxt;
  assign w_delta_nxt = w_err ? ui_in - w_exp : (uio_in[1] ? 8'd0 : r_delta);
  assign w_uo_nxt = uio_in[3]
    ? (uio_in[2] ? {w_state_nxt == LOCKED, w_state_nxt == ACQUIRE, 3'b0, w_miss_nxt} : w_delta_nxt)
    : (uio_in[2] ? w_exp_nxt : w_err_nxt);
  assign w_unused = &{ena, uio_in[7:4]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_delta <= 8'd0;
    else r_delta <= w_delta_nxt;
  end
`else
  assign w_uo_nxt = uio_in[2] ? w_exp_nxt : w_err_nxt;
  assign w_unused = &{ena, uio_in[7:3]};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prev      <= 8'd0;
      r_err_cnt   <= 8'd0;
      r_match_run <= 3'd0;
      r_miss_run  <= 3'd0;
      r_uo        <= 8'd0;
      r_locked    <= 1'b0;
      r_acq       <= 1'b0;
      r_sat       <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_err_cnt   <= w_err_nxt;
      r_match_run <= w_match_nxt;
      r_miss_run  <= w_miss_nxt;
      r_uo        <= w_uo_nxt;
      r_locked    <= w_state_nxt == LOCKED;
      r_acq       <= w_state_nxt == ACQUIRE;
      r_sat       <= w_err_nxt == 8'hFF;
      r_pulse     <= w_err;
    end
  end
  assign uo_out  = r_uo;
  assign uio_out = {r_acq, r_sat, r_pulse, r_locked, 4'b0};
  assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_count_checker.sv
// tb_tt_um_count_checker: directed plus randomized stream checks against a spec-level model of the count checker.
module tb_tt_um_count_checker;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  logic clk = 0, rst_n = 0, ena = 1;
  logic [7:0] ui_in = 0, uio_in = 0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int total = 0, bad = 0;
  bit chk_en = 0;
  int m_st, m_mrun, m_xrun;
  logic [7:0] m_prev, m_err, m_delta, m_s, m_want, m_expv, e_uo, e_uio;
  logic m_pulse;
  logic [7:0] p;

  tt_um_count_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // model: m_st 0=idle 1=acquire 2=locked
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_prev = 0; m_err = 0; m_delta = 0; m_mrun = 0; m_xrun = 0;
      m_pulse = 0; e_uo = 0; e_uio = 0;
    end else begin
      m_s = ui_in;
      m_want = m_prev + 8'd1;
      m_pulse = 0;
      if (uio_in[1]) begin m_err = 0; m_delta = 0; end
      if (uio_in[0]) begin
        if (m_st == 0) m_st = 1;
        else if (m_s == m_want) begin
          if (m_st == 1) begin
            m_mrun++;
            if (m_mrun == LOCK_CNT) begin m_st = 2; m_xrun = 0; end
          end else m_xrun = 0;
        end else if (m_st == 1) m_mrun = 0;
        else begin
          if (m_err != 8'hFF) m_err++;
          m_delta = m_s - m_want;
          m_pulse = 1;
          m_xrun++;
          if (m_xrun == LOSS_CNT) begin m_st = 1; m_mrun = 0; end
        end
        m_prev = m_s;
      end
      m_expv = (m_st == 0) ? 8'd0 : m_prev + 8'd1;
      e_uio = {m_st == 1, m_err == 8'hFF, m_pulse, m_st == 2, 4'b0};
`ifdef CHK_DELTA_EN
      case ({uio_in[3], uio_in[2]})
        2'b00: e_uo = m_err;
        2'b01: e_uo = m_expv;
        2'b10: e_uo = m_delta;
        default: e_uo = {m_st == 2, m_st == 1, 3'b0, 3'(m_xrun)};
      endcase
`else
      e_uo = uio_in[2] ? m_expv : m_err;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("uo_out", uo_out, e_uo);
      check("uio_out", uio_out, e_uio);
      check("uio_oe", uio_oe, 8'hF0);
    end
  end

  task automatic send(input bit v, input logic [7:0] s, input bit clr, input logic [1:0] sel);
    ui_in = s;
    uio_in = {4'b0, sel, clr, v};
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    for (int i = 10; i <= 14; i++) send(1, 8'(i), 0, 2'd0);
    check("lock_status", uio_out, 8'h10);
    check("lock_err", uo_out, 8'h00);
    send(1, 8'd15, 0, 2'd0);
    send(1, 8'd20, 0, 2'd0);
    check("pulse_after_20", uio_out, 8'h30);
    check("err_one", uo_out, 8'h01);
    send(1, 8'd21, 0, 2'd1);
    check("pulse_one_cycle", uio_out, 8'h10);
    send(1, 8'd22, 0, 2'd1);
    check("expected_23", uo_out, 8'd23);
    send(1, 8'd50, 0, 2'd0);
    send(1, 8'd90, 0, 2'd0);
    send(1, 8'd7, 0, 2'd0);
    check("err_four", uo_out, 8'd4);
    check("lock_lost", uio_out, 8'hA0);
    for (int i = 8; i <= 11; i++) send(1, 8'(i), 0, 2'd0);
    check("relock", uio_out, 8'h10);
    send(1, 8'd253, 0, 2'd0);
    send(1, 8'd254, 0, 2'd0);
    send(1, 8'd255, 0, 2'd0);
    send(1, 8'd0, 0, 2'd0);
    send(1, 8'd1, 0, 2'd1);
    check("wrap_expected", uo_out, 8'd2);
    send(0, 8'd0, 0, 2'd0);
    check("wrap_no_err", uo_out, 8'd5);
    p = 8'd1;
    for (int k = 0; k < 100; k++) begin
      for (int j = 0; j < 4; j++) begin p = p + 8'd1; send(1, p, 0, 2'd0); end
      for (int j = 0; j < 3; j++) begin p = p + 8'd100; send(1, p, 0, 2'd0); end
    end
    check("sat_cnt", uo_out, 8'hFF);
    check("sat_status", uio_out, 8'hE0);
    for (int j = 0; j < 4; j++) begin p = p + 8'd1; send(1, p, 0, 2'd0); end
    p = p + 8'd100;
    send(1, p, 1, 2'd0);
    check("clr_with_err", uo_out, 8'h01);
    check("clr_with_err_st", uio_out, 8'h30);
    send(0, 8'd0, 1, 2'd0);
    check("clr_alone", uo_out, 8'h00);
    p = p + 8'd1;
    send(1, p, 0, 2'd0);
    repeat (5) send(0, 8'd0, 0, 2'd0);
    p = p + 8'd1;
    send(1, p, 0, 2'd0);
    check("gap_match_err", uo_out, 8'h00);
    check("gap_match_st", uio_out, 8'h10);
    send(0, 8'd0, 0, 2'd1);
    check("gap_expected", uo_out, p + 8'd1);
    #2 rst_n = 0;
    #1;
    check("async_rst_uo", uo_out, 8'h00);
    check("async_rst_uio", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1;
    send(1, 8'd77, 0, 2'd0);
    send(1, 8'd3, 0, 2'd0);
    check("first_after_rst", uo_out, 8'h00);
    check("acq_after_rst", uio_out, 8'h80);
    p = 8'd3;
    for (int i = 0; i < 3000; i++) begin
      logic v, clr;
      logic [7:0] s;
      v = $urandom_range(3) != 0;
      s = ($urandom_range(9) < 8) ? p + 8'd1 : 8'($urandom);
      clr = $urandom_range(31) == 0;
      send(v, s, clr, 2'($urandom));
      if (v) p = s;
    end
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
